// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Pretends to be a matrix keypad so a keypad scanner can be driven by
//   commands. A command names a key and a hold time; while the key is held
//   the row line for that key is pulled low whenever the scanner strobes
//   the key's column. A forced-release gap follows every press so the
//   scanner sees a clean key-up.
//
// Ports
//   CLK2MHZ    sole clock, rising edge
//   rst        synchronous active-high reset
//   col[3:0]   active-low column strobe from the scanner
//   row[3:0]   active-low row lines back to the scanner (registered)
//   cmd_valid  press command present
//   cmd_ready  emulator idle and able to take a command
//   cmd_key    key code to press
//   cmd_hold   press duration in ticks (0 behaves as 1)
//   busy       high while pressing or releasing
//   done       one-cycle pulse when a press/release sequence completes
//   err        one-cycle pulse after an unmapped key code was accepted
module keypad_emulator #(
  parameter int TICK_CYCLES   = 2000,
  parameter int RELEASE_TICKS = 20
) (
  input  logic       CLK2MHZ,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_key,
  input  logic [7:0] cmd_hold,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int GW = (RELEASE_TICKS > 0) ? $clog2(RELEASE_TICKS + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(RELEASE_TICKS);

  typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

  typedef struct packed {
    logic       mapped;
    logic [3:0] col;
    logic [3:0] row;
  } key_pos_t;

  // Physical position of each key code in the matrix.
  function automatic key_pos_t key_lookup(input logic [3:0] code);
    key_pos_t p;
    p.mapped = 1'b1;
    p.col    = 4'b1111;
    p.row    = 4'b1111;
    case (code)
      4'h1: begin p.col = 4'b0111; p.row = 4'b0111; end
      4'h4: begin p.col = 4'b0111; p.row = 4'b1011; end
      4'h7: begin p.col = 4'b0111; p.row = 4'b1101; end
      4'hF: begin p.col = 4'b0111; p.row = 4'b1110; end
      4'h2: begin p.col = 4'b1011; p.row = 4'b0111; end
      4'h5: begin p.col = 4'b1011; p.row = 4'b1011; end
      4'h8: begin p.col = 4'b1011; p.row = 4'b1101; end
      4'h0: begin p.col = 4'b1011; p.row = 4'b1110; end
      4'h3: begin p.col = 4'b1101; p.row = 4'b0111; end
      4'h6: begin p.col = 4'b1101; p.row = 4'b1011; end
      4'h9: begin p.col = 4'b1101; p.row = 4'b1101; end
      4'hA: begin p.col = 4'b1110; p.row = 4'b0111; end
      4'hB: begin p.col = 4'b1110; p.row = 4'b1011; end
      4'hC: begin p.col = 4'b1110; p.row = 4'b1101; end
      default: p.mapped = 1'b0;
    endcase
    return p;
  endfunction

  state_t        state_reg, state_next;
  logic [TW-1:0] tick_reg,  tick_next;
  logic [7:0]    hold_reg,  hold_next;
  logic [GW-1:0] gap_reg,   gap_next;
  logic [3:0]    key_reg,   key_next;
  logic [3:0]    row_reg,   row_next;
  logic          done_reg,  done_next;
  logic          err_reg,   err_next;
  logic          tick_wrap;
  key_pos_t      cmd_pos;
  key_pos_t      cur_pos;

  assign tick_wrap = (tick_reg == TICK_LAST);
  assign cmd_pos   = key_lookup(cmd_key);

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    hold_next  = hold_reg;
    gap_next   = gap_reg;
    key_next   = key_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        tick_next = '0;
        if (cmd_valid) begin
          if (cmd_pos.mapped) begin
            state_next = PRESS;
            key_next   = cmd_key;
            hold_next  = (cmd_hold == 8'd0) ? 8'd1 : cmd_hold;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      PRESS: begin
        tick_next = tick_wrap ? '0 : tick_reg + TW'(1);
        if (tick_wrap) begin
          hold_next = hold_reg - 8'd1;
          // Last tick of the hold: leave PRESS so the press spans
          // exactly hold*TICK_CYCLES cycles.
          if (hold_reg <= 8'd1) begin
            state_next = RELEASE;
            hold_next  = '0;
            gap_next   = GAP_LOAD;
          end
        end
      end

      RELEASE: begin
        tick_next = tick_wrap ? '0 : tick_reg + TW'(1);
        if (gap_reg == '0) begin
          // Zero-length gap still costs the single cycle spent here.
          state_next = IDLE;
          done_next  = 1'b1;
          tick_next  = '0;
        end else if (tick_wrap) begin
          gap_next = gap_reg - GW'(1);
          if (gap_reg == GW'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
            tick_next  = '0;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    // Row is driven from the state being entered, so the first PRESS
    // cycle already answers the column seen on the accept cycle and the
    // first RELEASE cycle is already released.
    cur_pos  = key_lookup(key_next);
    row_next = 4'b1111;
    if (state_next == PRESS && col == cur_pos.col) begin
      row_next = cur_pos.row;
    end
  end

  always_ff @(posedge CLK2MHZ) begin
    if (rst) begin
      state_reg <= IDLE;
      tick_reg  <= '0;
      hold_reg  <= '0;
      gap_reg   <= '0;
      key_reg   <= '0;
      row_reg   <= 4'b1111;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      hold_reg  <= hold_next;
      gap_reg   <= gap_next;
      key_reg   <= key_next;
      row_reg   <= row_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign row       = row_reg;
  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

  localparam int TC = 4;
  localparam int RT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col;
  logic [3:0] row;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_key;
  logic [7:0] cmd_hold;
  logic       busy;
  logic       done;
  logic       err;

  keypad_emulator #(.TICK_CYCLES(TC), .RELEASE_TICKS(RT)) dut (
    .CLK2MHZ  (clk),
    .rst      (rst),
    .col      (col),
    .row      (row),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_key  (cmd_key),
    .cmd_hold (cmd_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Keypad layout: grid[column index][row index] = key code, -1 = no key.
  // Column/row index i corresponds to active-low pattern ~(4'b1000 >> i).
  int grid [4][4] = '{'{1, 4, 7, 15}, '{2, 5, 8, 0}, '{3, 6, 9, -1}, '{10, 11, 12, -1}};

  int checks = 0;
  int errors = 0;

  // Reference model: a press is described by its cycle window only.
  int cyc = 0;
  int press_first = -1;
  int press_last  = -2;
  int busy_until  = -2;
  int done_at     = -1;
  int err_at      = -1;
  int m_key       = 0;
  logic [3:0] col_prev = 4'b1111;

  // Scenario observation
  int  row_active = 0;
  int  done_seen  = 0;
  int  err_seen   = 0;
  bit  dut_accept = 0;
  int  acc_cyc    = -1;

  int         col_mode  = 0;
  logic [3:0] col_fixed = 4'b1111;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit find_key(input int code, output logic [3:0] kc, output logic [3:0] kr);
    logic [3:0] p;
    kc = 4'b1111;
    kr = 4'b1111;
    for (int ci = 0; ci < 4; ci++) begin
      for (int ri = 0; ri < 4; ri++) begin
        if (grid[ci][ri] == code) begin
          p  = 4'b1000 >> ci;
          kc = ~p;
          p  = 4'b1000 >> ri;
          kr = ~p;
          return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    press_first = -1;
    press_last  = -2;
    busy_until  = -2;
    done_at     = -1;
    err_at      = -1;
  endtask

  task automatic drive_col();
    logic [3:0] p;
    case (col_mode)
      0: begin p = 4'b1000 >> (cyc % 4); col = ~p; end
      1: col = col_fixed;
      default: begin
        if ($urandom_range(0, 3) == 0) col = 4'($urandom_range(0, 15));
        else begin p = 4'b1000 >> $urandom_range(0, 3); col = ~p; end
      end
    endcase
  endtask

  // One clock cycle: compare outputs against the model, then advance it.
  task automatic tick();
    logic [3:0] kc, kr, row_exp, ckc, ckr;
    bit in_press, busy_exp, mapped;
    int h;
    @(negedge clk);
    in_press = (cyc >= press_first) && (cyc <= press_last);
    busy_exp = (cyc >= press_first) && (cyc <= busy_until);
    mapped   = find_key(m_key, kc, kr);
    row_exp  = (in_press && mapped && col_prev == kc) ? kr : 4'b1111;
    check_val("row", 32'(row), 32'(row_exp));
    check_val("busy", 32'(busy), 32'(busy_exp));
    check_val("cmd_ready", 32'(cmd_ready), 32'(!busy_exp));
    check_val("done", 32'(done), 32'(cyc == done_at));
    check_val("err", 32'(err), 32'(cyc == err_at));
    if (row != 4'b1111) row_active++;
    if (done) done_seen++;
    if (err) err_seen++;
    dut_accept = cmd_valid && cmd_ready && !rst;
    if (dut_accept) acc_cyc = cyc;

    if (rst) begin
      model_reset();
    end else if (cmd_valid && !busy_exp) begin
      if (find_key(int'(cmd_key), ckc, ckr)) begin
        h           = (cmd_hold == 8'd0) ? 1 : int'(cmd_hold);
        m_key       = int'(cmd_key);
        press_first = cyc + 1;
        press_last  = cyc + h * TC;
        busy_until  = press_last + ((RT == 0) ? 1 : RT * TC);
        done_at     = busy_until + 1;
      end else begin
        err_at = cyc + 1;
      end
    end
    col_prev = col;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive_col();
      tick();
    end
  endtask

  task automatic issue(input logic [3:0] k, input logic [7:0] h, input bit keep_valid);
    int n;
    cmd_key   = k;
    cmd_hold  = h;
    cmd_valid = 1'b1;
    n = 0;
    do begin
      drive_col();
      tick();
      n++;
    end while (!dut_accept && n < 200);
    check_val("accept_within_bound", 32'(dut_accept), 32'd1);
    $display("cmd key=%0h hold=%0d accepted at cycle %0d", k, h, acc_cyc);
    if (!keep_valid) cmd_valid = 1'b0;
  endtask

  task automatic clear_obs();
    row_active = 0;
    done_seen  = 0;
    err_seen   = 0;
  endtask

  initial begin
    int acc1;
    rst       = 1'b1;
    col       = 4'b1111;
    cmd_valid = 1'b0;
    cmd_key   = 4'h0;
    cmd_hold  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    // A command during reset must be ignored.
    cmd_valid = 1'b1;
    cmd_key   = 4'h5;
    tick();
    cmd_valid = 1'b0;
    rst = 1'b0;
    col_mode = 0;
    run(3);

    // Key 5, hold 3, cycling columns
    clear_obs();
    issue(4'h5, 8'd3, 1'b0);
    run(30);
    check_val("k5_row_active_cycles", 32'(row_active), 32'd3);
    check_val("k5_done_pulses", 32'(done_seen), 32'd1);

    // Key C, hold 1, column fixed on its strobe
    col_mode = 1; col_fixed = 4'b1110;
    clear_obs();
    issue(4'hC, 8'd1, 1'b0);
    run(15);
    check_val("kC_row_active_cycles", 32'(row_active), 32'd4);
    check_val("kC_done_pulses", 32'(done_seen), 32'd1);

    // Column released mid-press
    clear_obs();
    issue(4'hC, 8'd2, 1'b0);
    run(3);
    col_fixed = 4'b1111;
    run(2);
    col_fixed = 4'b1110;
    run(15);
    check_val("kC_gap_row_active_cycles", 32'(row_active), 32'd6);

    // Unmapped codes
    clear_obs();
    issue(4'hE, 8'd3, 1'b0);
    run(4);
    issue(4'hD, 8'd1, 1'b0);
    run(4);
    check_val("unmapped_err_pulses", 32'(err_seen), 32'd2);
    check_val("unmapped_row_active", 32'(row_active), 32'd0);
    check_val("unmapped_done_pulses", 32'(done_seen), 32'd0);

    // Hold 0 behaves as hold 1
    col_fixed = 4'b0111;
    clear_obs();
    issue(4'h1, 8'd0, 1'b0);
    run(15);
    check_val("hold0_row_active_cycles", 32'(row_active), 32'd4);

    // Reset two cycles into a press
    clear_obs();
    issue(4'hF, 8'd5, 1'b0);
    run(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(30);
    check_val("rst_mid_press_row_active", 32'(row_active), 32'd2);
    check_val("rst_mid_press_done", 32'(done_seen), 32'd0);

    // Back-to-back with cmd_valid held high
    col_mode = 0;
    clear_obs();
    issue(4'h2, 8'd1, 1'b1);
    acc1 = acc_cyc;
    issue(4'h3, 8'd1, 1'b0);
    check_val("b2b_accept_spacing", 32'(acc_cyc - acc1), 32'(TC + RT * TC + 1));
    run(20);
    check_val("b2b_done_pulses", 32'(done_seen), 32'd2);

    // Random traffic
    col_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      cmd_valid = ($urandom_range(0, 9) < 3);
      cmd_key   = 4'($urandom_range(0, 15));
      cmd_hold  = 8'($urandom_range(0, 3));
      drive_col();
      tick();
      if (dut_accept) $display("rand cmd key=%0h hold=%0d accepted at cycle %0d", cmd_key, cmd_hold, acc_cyc);
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    run(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter TICK_CYCLES, default 2000, meaning CLK2MHZ cycles per hold/gap tick (1 ms at 2 MHz).
REQ-002 Parameter RELEASE_TICKS, default 20, meaning ticks of forced release (row=4'b1111) after each press.
REQ-003 CLK2MHZ  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 col  input  4  active-low column strobe from keypad scanner.
REQ-006 row  output 4  active-low row lines to the scanner; registered.
REQ-007 cmd_valid  input  1  press command present.
REQ-008 cmd_ready  output 1  emulator can accept a command.
REQ-009 cmd_key  input  4  key code to press (keypad code set).
REQ-010 cmd_hold  input  8  press duration in ticks; 0 treated as 1.
REQ-011 busy  output 1  high in PRESS or RELEASE.
REQ-012 done  output 1  one-cycle pulse when a press/release sequence completes.
REQ-013 err  output 1  one-cycle pulse when an unmapped key code is accepted.

Function
REQ-014 Key map (col -> row -> code) SHALL be: col 0111: row 0111=1, 1011=4, 1101=7, 1110=F(clear); col 1011: 0111=2, 1011=5, 1101=8, 1110=0; col 1101: 0111=3, 1011=6, 1101=9; col 1110: 0111=A(+), 1011=B(-), 1101=C(=).
REQ-015 Codes D and E SHALL be unmapped.
REQ-016 States SHALL be IDLE, PRESS, RELEASE.
REQ-017 IDLE: cmd_ready=1, busy=0, row=4'b1111.
REQ-018 Handshake: command accepted on a cycle with cmd_valid=1 and cmd_ready=1; cmd_key/cmd_hold latched that cycle.
REQ-019 Accepted mapped code: next state PRESS; hold counter loaded with max(cmd_hold,1); tick counter cleared.
REQ-020 Accepted unmapped code: err=1 the following cycle; state stays IDLE; no row activity.
REQ-021 cmd_ready SHALL be 0 in PRESS and RELEASE; cmd_valid ignored there.
REQ-022 PRESS: each cycle, row <= latched key's row pattern if col equals exactly that key's column pattern, else 4'b1111 (one-cycle col->row latency).
REQ-023 col with zero or multiple low bits SHALL yield row=4'b1111.
REQ-024 Tick counter counts 0..TICK_CYCLES-1 and wraps; each wrap decrements hold counter.
REQ-025 Hold counter reaching 0: next state RELEASE, row=4'b1111 from that cycle, tick counter cleared, gap counter loaded with RELEASE_TICKS.
REQ-026 PRESS duration SHALL be exactly hold*TICK_CYCLES cycles.
REQ-027 RELEASE: row=4'b1111; gap counter decrements per tick wrap; at 0, done=1 for one cycle and state returns to IDLE.
REQ-028 RELEASE duration SHALL be exactly RELEASE_TICKS*TICK_CYCLES cycles; RELEASE_TICKS=0 gives a 1-cycle RELEASE.
REQ-029 A command may be accepted on the cycle done is asserted (back-to-back).
REQ-030 Counters SHALL be wide enough for parameter values without overflow.

Reset
REQ-031 rst=1 at any time, including mid-PRESS or mid-RELEASE: next edge state=IDLE, row=4'b1111, cmd_ready=1, busy=0, done=0, err=0, all counters 0, latched key cleared.
REQ-032 A command presented while rst=1 SHALL NOT be accepted.

Verification (TICK_CYCLES=4, RELEASE_TICKS=2)
REQ-033 cmd_key=5, cmd_hold=3, col cycling 0111/1011/1101/1110 -> row=4'b1011 only one cycle after col=1011, for 12 cycles; then 8 cycles row=1111; done pulse; cmd_ready back to 1.
REQ-034 cmd_key=C, hold=1, col fixed 1110 -> row=4'b1101 for 4 cycles, then 1111; col=1111 at any time -> row=1111 next cycle.
REQ-035 cmd_key=E -> err pulse one cycle later, row stays 1111, cmd_ready stays 1, busy stays 0.
REQ-036 cmd_hold=0 with key 1 -> identical to hold=1 (4-cycle PRESS, row=0111 when col=0111).
REQ-037 rst asserted 2 cycles into PRESS of key F -> row=1111 and IDLE next edge; no done pulse.
REQ-038 cmd_valid held high with keys 2 then 3 -> second accepted on done cycle; both presses with 8-cycle release gap between.
